// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one shared memory port,
// one transaction in flight, with a starvation guard that eventually forces fetch through.
module mem_port_arbiter #(
    parameter int BIN_DIG      = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               if_req,
    input  logic [BIN_DIG-1:0] if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [BIN_DIG-1:0] if_rdata,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [BIN_DIG-1:0] dm_addr,
    input  logic [BIN_DIG-1:0] dm_wdata,
    input  logic [3:0]         dm_be,
    output logic               dm_gnt,
    output logic               dm_rvalid,
    output logic [BIN_DIG-1:0] dm_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [BIN_DIG-1:0] mem_addr,
    output logic [BIN_DIG-1:0] mem_wdata,
    output logic [3:0]         mem_be,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [BIN_DIG-1:0] mem_rdata,
    output logic               proto_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    // Wide enough to hold STARVE_LIMIT, and never zero bits wide.
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t             state_q, state_d;
    logic               owner_dm_q, owner_dm_d;
    logic [CW-1:0]      starve_cnt_q, starve_cnt_d;
    logic               mem_we_q, mem_we_d;
    logic [BIN_DIG-1:0] mem_addr_q, mem_addr_d;
    logic [BIN_DIG-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic               proto_err_q, proto_err_d;
    logic               fetch_wins;

    assign fetch_wins = if_req && (!dm_req || (starve_cnt_q >= LIMIT));

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        owner_dm_d   = owner_dm_q;
        starve_cnt_d = starve_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        proto_err_d  = proto_err_q;
        if_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        if_rdata     = '0;
        dm_gnt       = 1'b0;
        dm_rvalid    = 1'b0;
        dm_rdata     = '0;

        // Handshake outputs stay quiet while reset is held, even though state clears only at the edge.
        if (!RST) begin
            case (state_q)
                IDLE: begin
                    if (mem_rvalid) proto_err_d = 1'b1;
                    if (if_req || dm_req) begin
                        state_d = REQ;
                        if (fetch_wins) begin
                            if_gnt       = 1'b1;
                            owner_dm_d   = 1'b0;
                            mem_we_d     = 1'b0;
                            mem_addr_d   = if_addr;
                            mem_wdata_d  = '0;
                            mem_be_d     = 4'hF;
                            starve_cnt_d = '0;
                        end else begin
                            dm_gnt      = 1'b1;
                            owner_dm_d  = 1'b1;
                            mem_we_d    = dm_we;
                            mem_addr_d  = dm_addr;
                            mem_wdata_d = dm_wdata;
                            mem_be_d    = dm_be;
                            if (if_req && (starve_cnt_q < LIMIT)) starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_rvalid) proto_err_d = 1'b1;
                    if (mem_gnt) state_d = mem_we_q ? IDLE : RESP;
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state_d = IDLE;
                        if (owner_dm_q) begin
                            dm_rvalid = 1'b1;
                            dm_rdata  = mem_rdata;
                        end else begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the latched request fields are reset too, because they drive module outputs directly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            owner_dm_q   <= 1'b0;
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= 4'h0;
            proto_err_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q      <= state_d;
            owner_dm_q   <= owner_dm_d;
            starve_cnt_q <= starve_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-by-cycle vector table for the basic transactions, followed by directed
// sequences for starvation, a stalled memory and reset in the middle of a read.
module tb_mem_port_arbiter;

    typedef logic [31:0] w_t;

    typedef struct {
        w_t rst, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_gnt, mem_rvalid, mem_rdata;
        w_t e_if_gnt, e_if_rvalid, e_if_rdata, e_dm_gnt, e_dm_rvalid, e_dm_rdata;
        w_t e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata, e_mem_be, e_proto_err;
    } vec_t;

    logic        CLK, RST;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be, mem_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, proto_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    vec_t vecs[18];

    mem_port_arbiter #(.BIN_DIG(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input int idx, input vec_t v);
        tick();
        RST        = v.rst[0];
        if_req     = v.if_req[0];
        if_addr    = v.if_addr;
        dm_req     = v.dm_req[0];
        dm_we      = v.dm_we[0];
        dm_addr    = v.dm_addr;
        dm_wdata   = v.dm_wdata;
        dm_be      = v.dm_be[3:0];
        mem_gnt    = v.mem_gnt[0];
        mem_rvalid = v.mem_rvalid[0];
        mem_rdata  = v.mem_rdata;
        @(negedge CLK);
        check($sformatf("v%0d if_gnt", idx),    32'(if_gnt),    v.e_if_gnt);
        check($sformatf("v%0d if_rvalid", idx), 32'(if_rvalid), v.e_if_rvalid);
        check($sformatf("v%0d if_rdata", idx),  if_rdata,       v.e_if_rdata);
        check($sformatf("v%0d dm_gnt", idx),    32'(dm_gnt),    v.e_dm_gnt);
        check($sformatf("v%0d dm_rvalid", idx), 32'(dm_rvalid), v.e_dm_rvalid);
        check($sformatf("v%0d dm_rdata", idx),  dm_rdata,       v.e_dm_rdata);
        check($sformatf("v%0d mem_req", idx),   32'(mem_req),   v.e_mem_req);
        check($sformatf("v%0d mem_we", idx),    32'(mem_we),    v.e_mem_we);
        check($sformatf("v%0d mem_addr", idx),  mem_addr,       v.e_mem_addr);
        check($sformatf("v%0d mem_wdata", idx), mem_wdata,      v.e_mem_wdata);
        check($sformatf("v%0d mem_be", idx),    32'(mem_be),    v.e_mem_be);
        check($sformatf("v%0d proto_err", idx), 32'(proto_err), v.e_proto_err);
    endtask

    initial begin
        // rst if_req if_addr dm_req dm_we dm_addr dm_wdata dm_be mem_gnt mem_rvalid mem_rdata |
        // if_gnt if_rvalid if_rdata dm_gnt dm_rvalid dm_rdata mem_req mem_we mem_addr mem_wdata mem_be proto_err
        vecs[0]  = '{1, 0, 0,      0, 0, 0,      0,           0,     0, 0, 0,            0, 0, 0,            0, 0, 0,       0, 0, 0,      0,           0,     0};
        vecs[1]  = '{0, 1, 'h100,  0, 0, 0,      0,           0,     0, 0, 0,            1, 0, 0,            0, 0, 0,       0, 0, 0,      0,           0,     0};
        vecs[2]  = '{0, 0, 'h100,  0, 0, 0,      0,           0,     1, 0, 0,            0, 0, 0,            0, 0, 0,       1, 0, 'h100,  0,           'hF,   0};
        vecs[3]  = '{0, 0, 'h100,  0, 0, 0,      0,           0,     0, 1, 'h13,         0, 1, 'h13,         0, 0, 0,       0, 0, 'h100,  0,           'hF,   0};
        vecs[4]  = '{0, 0, 0,      0, 0, 0,      0,           0,     0, 0, 'h13,         0, 0, 0,            0, 0, 0,       0, 0, 'h100,  0,           'hF,   0};
        vecs[5]  = '{0, 1, 'h104,  1, 1, 'h200,  'hDEADBEEF,  'hF,   0, 0, 0,            0, 0, 0,            1, 0, 0,       0, 0, 'h100,  0,           'hF,   0};
        vecs[6]  = '{0, 1, 'h104,  0, 0, 0,      0,           0,     1, 0, 0,            0, 0, 0,            0, 0, 0,       1, 1, 'h200,  'hDEADBEEF,  'hF,   0};
        vecs[7]  = '{0, 1, 'h104,  0, 0, 0,      0,           0,     0, 0, 0,            1, 0, 0,            0, 0, 0,       0, 1, 'h200,  'hDEADBEEF,  'hF,   0};
        vecs[8]  = '{0, 0, 0,      0, 0, 0,      0,           0,     1, 0, 0,            0, 0, 0,            0, 0, 0,       1, 0, 'h104,  0,           'hF,   0};
        vecs[9]  = '{0, 0, 0,      0, 0, 0,      0,           0,     0, 1, 'hCAFEF00D,   0, 1, 'hCAFEF00D,   0, 0, 0,       0, 0, 'h104,  0,           'hF,   0};
        vecs[10] = '{0, 0, 0,      1, 0, 'h300,  'h11111111,  'h3,   0, 0, 0,            0, 0, 0,            1, 0, 0,       0, 0, 'h104,  0,           'hF,   0};
        vecs[11] = '{0, 0, 0,      0, 0, 0,      0,           0,     0, 0, 0,            0, 0, 0,            0, 0, 0,       1, 0, 'h300,  'h11111111,  'h3,   0};
        vecs[12] = '{0, 0, 0,      0, 0, 0,      0,           0,     1, 0, 0,            0, 0, 0,            0, 0, 0,       1, 0, 'h300,  'h11111111,  'h3,   0};
        vecs[13] = '{0, 0, 0,      0, 0, 0,      0,           0,     0, 1, 'h55AA,       0, 0, 0,            0, 1, 'h55AA,  0, 0, 'h300,  'h11111111,  'h3,   0};
        vecs[14] = '{0, 0, 0,      0, 0, 0,      0,           0,     0, 1, 'h77,         0, 0, 0,            0, 0, 0,       0, 0, 'h300,  'h11111111,  'h3,   0};
        vecs[15] = '{0, 0, 0,      0, 0, 0,      0,           0,     0, 0, 0,            0, 0, 0,            0, 0, 0,       0, 0, 'h300,  'h11111111,  'h3,   1};
        vecs[16] = '{1, 1, 'h108,  1, 0, 'h304,  0,           'hF,   0, 0, 0,            0, 0, 0,            0, 0, 0,       0, 0, 'h300,  'h11111111,  'h3,   1};
        vecs[17] = '{0, 0, 0,      0, 0, 0,      0,           0,     0, 0, 0,            0, 0, 0,            0, 0, 0,       0, 0, 0,      0,           0,     0};

        RST = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; dm_be = 4'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge CLK);

        foreach (vecs[i]) step(i, vecs[i]);

        // Starvation: both sides keep requesting; dmem wins four times, the fifth arbitration goes to fetch.
        for (int k = 1; k <= 6; k++) begin
            tick();
            if_req = 1'b1; if_addr = 32'h180;
            dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400 + 32'(k * 4); dm_wdata = 32'(k); dm_be = 4'hF;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            @(negedge CLK);
            check($sformatf("starve arb%0d if_gnt", k), 32'(if_gnt), (k == 5) ? 32'd1 : 32'd0);
            check($sformatf("starve arb%0d dm_gnt", k), 32'(dm_gnt), (k == 5) ? 32'd0 : 32'd1);
            if (k == 6) break;
            tick();
            mem_gnt = 1'b1;
            @(negedge CLK);
            check($sformatf("starve req%0d mem_req", k), 32'(mem_req), 32'd1);
            check($sformatf("starve req%0d mem_addr", k), mem_addr, (k == 5) ? 32'h180 : 32'h400 + 32'(k * 4));
            check($sformatf("starve req%0d no gnt", k), 32'({if_gnt, dm_gnt}), 32'd0);
            if (k == 5) begin
                tick();
                mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
                @(negedge CLK);
                check("starve fetch if_rvalid", 32'(if_rvalid), 32'd1);
                check("starve fetch if_rdata", if_rdata, 32'hA5A5_0001);
                check("starve fetch dm_rvalid", 32'(dm_rvalid), 32'd0);
            end
        end

        // Stalled memory: the sixth (dmem) request sits in REQ for 10 cycles with no grant.
        for (int c = 0; c < 10; c++) begin
            tick();
            mem_gnt = 1'b0;
            @(negedge CLK);
            check($sformatf("stall c%0d mem_req", c), 32'(mem_req), 32'd1);
            check($sformatf("stall c%0d mem_addr", c), mem_addr, 32'h418);
            check($sformatf("stall c%0d mem_wdata", c), mem_wdata, 32'd6);
            check($sformatf("stall c%0d no gnt", c), 32'({if_gnt, dm_gnt}), 32'd0);
        end
        tick();
        mem_gnt = 1'b1;
        @(negedge CLK);
        check("stall release mem_req", 32'(mem_req), 32'd1);

        // Reset while a fetch read is waiting in RESP, then a stray mem_rvalid right after reset.
        tick();
        mem_gnt = 1'b0; dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h1C0;
        @(negedge CLK);
        check("rst-resp if_gnt", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0; mem_gnt = 1'b1;
        @(negedge CLK);
        check("rst-resp mem_addr", mem_addr, 32'h1C0);
        tick();
        mem_gnt = 1'b0; RST = 1'b1;
        @(negedge CLK);
        check("rst-resp rvalid during rst", 32'({if_rvalid, dm_rvalid}), 32'd0);
        tick();
        RST = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
        @(negedge CLK);
        check("post-rst if_rvalid", 32'(if_rvalid), 32'd0);
        check("post-rst dm_rvalid", 32'(dm_rvalid), 32'd0);
        check("post-rst if_rdata", if_rdata, 32'd0);
        check("post-rst mem_req", 32'(mem_req), 32'd0);
        check("post-rst mem_addr", mem_addr, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        @(negedge CLK);
        check("post-rst proto_err", 32'(proto_err), 32'd1);
        check("post-rst mem_fields", 32'({mem_req, mem_we, mem_be}), 32'd0);
        check("post-rst mem_wdata", mem_wdata, 32'd0);
        check("post-rst mem_addr2", mem_addr, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
